// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - byte FIFO feeding a UART transmitter via a start/ready handshake
// Optional feature: define UART_TXQ_LEVEL_EN to expose the occupancy count on the level port.
module uart_tx_queue #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [7:0]            wr_data,
   output logic                  full,
   output logic                  empty,
   output logic                  overflow,
   output logic                  tx_start,
   output logic [7:0]            tx_data,
   input  logic                  tx_ready
`ifdef UART_TXQ_LEVEL_EN
   ,
   output logic [DEPTH_LOG2:0]   level
`endif
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_PULSE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  push;
   logic                  pop;

   // Flags come straight from the registered count, so a push while full is
   // refused even when a pop frees a slot on the same edge.
   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);
   assign push  = wr_en && !full;
   assign pop   = (state == S_IDLE) && !empty && tx_ready;

`ifdef UART_TXQ_LEVEL_EN
   assign level = count;
`endif

   // Storage array; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers, occupancy, sticky overflow and the registered transmit byte.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         tx_data  <= 8'h00;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr  <= rd_ptr + 1'b1;
            tx_data <= mem[rd_ptr];
         end
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Handshake state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and start pulse: WAIT_BUSY absorbs the transmitter's late ready drop.
   always_comb begin
      state_nxt = state;
      tx_start  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty && tx_ready) begin
               state_nxt = S_PULSE;
            end
         end
         S_PULSE: begin
            tx_start  = 1'b1;
            state_nxt = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (!tx_ready) begin
               state_nxt = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (tx_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - self-checking bench for uart_tx_queue with a transmitter model
module tb_uart_tx_queue;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_ready;
`ifdef UART_TXQ_LEVEL_EN
   logic [4:0] level;
`endif

   uart_tx_queue #(.DEPTH_LOG2(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .overflow (overflow),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_ready (tx_ready)
`ifdef UART_TXQ_LEVEL_EN
      ,
      .level    (level)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Transmitter model state
   bit       force_low = 1'b0;
   int       rise_dly  = 20;
   int       fall_cnt  = 0;
   int       low_cnt   = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];

   typedef struct {
      int n_push;
      bit exp_full;
      bit exp_empty;
      bit exp_ovf;
      int exp_level;
   } vec_t;

   vec_t vecs[6];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Transmitter: captures data on start, drops ready 2 cycles later, raises it rise_dly cycles after that.
   initial begin
      bit started;
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         started = tx_start;
         if (started) begin
            checks++;
            if (!tx_ready || fall_cnt != 0 || low_cnt != 0) begin
               errors++;
               $display("FAIL start_while_busy: ready=%0b fall=%0d low=%0d, required idle transmitter",
                        tx_ready, fall_cnt, low_cnt);
            end
            rx_q.push_back(tx_data);
         end
         if (fall_cnt > 0) begin
            fall_cnt--;
            if (fall_cnt == 0) begin
               tx_ready = 1'b0;
               low_cnt  = rise_dly;
            end
         end else if (low_cnt > 0) begin
            low_cnt--;
            if (low_cnt == 0) tx_ready = !force_low;
         end else begin
            tx_ready = !force_low;
         end
         if (started) fall_cnt = 2;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic do_reset();
      rst   = 1'b0;
      wr_en = 1'b0;
      repeat (2) step();
      rst = 1'b1;
      step();
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_tx_idle();
      int c = 0;
      while ((fall_cnt != 0 || low_cnt != 0) && c < 200) begin
         step();
         c++;
      end
      check("tx_idle_timeout", (fall_cnt == 0 && low_cnt == 0), 1);
   endtask

   task automatic wait_rx(input int n, input int budget, input string name);
      int c = 0;
      while (rx_q.size() < n && c < budget) begin
         step();
         c++;
      end
      check(name, rx_q.size(), n);
   endtask

   task automatic compare_rx(input string name);
      check({name, "_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         check({name, "_byte"}, rx_q[i], exp_q[i]);
      end
   endtask

   initial begin
      int v;
      int n0;
      int c;

      vecs[0] = '{0,  1'b0, 1'b1, 1'b0, 0};
      vecs[1] = '{1,  1'b0, 1'b0, 1'b0, 1};
      vecs[2] = '{15, 1'b0, 1'b0, 1'b0, 15};
      vecs[3] = '{16, 1'b1, 1'b0, 1'b0, 16};
      vecs[4] = '{17, 1'b1, 1'b0, 1'b1, 16};
      vecs[5] = '{20, 1'b1, 1'b0, 1'b1, 16};

      rst = 1'b0;
      wr_en = 1'b0;
      wr_data = 8'h00;
      repeat (2) step();
      #1;
      check("reset_tx_start", tx_start, 0);
      check("reset_tx_data", tx_data, 8'h00);
      check("reset_full", full, 0);
      check("reset_empty", empty, 1);
      check("reset_overflow", overflow, 0);
`ifdef UART_TXQ_LEVEL_EN
      check("reset_level", level, 0);
`endif
      rst = 1'b1;
      step();

      // Occupancy flags with the transmitter held busy
      force_low = 1'b1;
      for (int k = 0; k < 6; k++) begin
         do_reset();
         for (int i = 0; i < vecs[k].n_push; i++) push(8'(i));
         @(negedge clk);
         check("tbl_full", full, vecs[k].exp_full);
         check("tbl_empty", empty, vecs[k].exp_empty);
         check("tbl_overflow", overflow, vecs[k].exp_ovf);
         check("tbl_start_held", tx_start, 0);
`ifdef UART_TXQ_LEVEL_EN
         check("tbl_level", level, vecs[k].exp_level);
`endif
         step();
      end

      // Single byte: wr_en presented after edge N, accepted at N+1, start during cycle after N+2
      force_low = 1'b0;
      rise_dly = 20;
      do_reset();
      wait_tx_idle();
      wr_en = 1'b1;
      wr_data = 8'hA5;
      step();
      wr_en = 1'b0;
      @(negedge clk);
      check("single_empty_after_push", empty, 0);
      check("single_no_early_start", tx_start, 0);
      @(negedge clk);
      check("single_start", tx_start, 1);
      check("single_data", tx_data, 8'hA5);
      exp_q.push_back(8'hA5);
      step();
      wait_rx(1, 100, "single_rx_timeout");
      repeat (30) step();
      compare_rx("single");
      check("single_empty_after_pop", empty, 1);

      // Burst ordering
      do_reset();
      wait_tx_idle();
      for (int i = 1; i <= 3; i++) begin
         push(8'(i));
         exp_q.push_back(8'(i));
      end
      wait_rx(3, 200, "burst_rx_timeout");
      compare_rx("burst");

      // Fill and overflow, then drain
      force_low = 1'b1;
      do_reset();
      for (int i = 0; i < 17; i++) begin
         push(8'h40 + 8'(i));
         if (i < 16) exp_q.push_back(8'h40 + 8'(i));
         if (i == 15) begin
            check("fill_full_16", full, 1);
            check("fill_ovf_16", overflow, 0);
         end
      end
      check("fill_ovf_17", overflow, 1);
      check("fill_full_17", full, 1);
      force_low = 1'b0;
      wait_rx(16, 16 * 40, "fill_rx_timeout");
      repeat (60) step();
      compare_rx("fill");
      check("fill_empty_after", empty, 1);
      check("fill_ovf_sticky", overflow, 1);

      // Wrap-around with random bursts and random transmitter recovery
      do_reset();
      wait_tx_idle();
      v = 0;
      while (v < 40) begin
         rise_dly = $urandom_range(3, 25);
         for (int b = $urandom_range(1, 6); b > 0 && v < 40; b--) begin
            push(8'(v));
            exp_q.push_back(8'(v));
            v++;
         end
         c = 0;
         while (v - rx_q.size() > 8 && c < 1000) begin
            step();
            c++;
         end
         repeat ($urandom_range(0, 5)) step();
      end
      wait_rx(40, 2000, "wrap_rx_timeout");
      compare_rx("wrap");
      check("wrap_no_overflow", overflow, 0);

      // Push in the same cycle the FSM pops, with 5 queued
      rise_dly = 20;
      wait_tx_idle();
      force_low = 1'b1;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         push(8'h60 + 8'(i));
         exp_q.push_back(8'h60 + 8'(i));
      end
      force_low = 1'b0;
      push(8'h65);
      exp_q.push_back(8'h65);
      @(negedge clk);
      check("conc_start", tx_start, 1);
      check("conc_data", tx_data, 8'h60);
`ifdef UART_TXQ_LEVEL_EN
      check("conc_level", level, 5);
`endif
      step();
      wait_rx(6, 400, "conc_rx_timeout");
      compare_rx("conc");

      // Reset while waiting for the transmitter to go busy, 3 bytes still queued
      wait_tx_idle();
      force_low = 1'b1;
      do_reset();
      for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
      force_low = 1'b0;
      c = 0;
      while (!tx_start && c < 20) begin
         step();
         c++;
      end
      check("rst_first_start", tx_start, 1);
      step();
      rst = 1'b0;
      #1;
      check("rst_async_start", tx_start, 0);
      check("rst_async_data", tx_data, 8'h00);
      check("rst_async_full", full, 0);
      check("rst_async_empty", empty, 1);
      check("rst_async_ovf", overflow, 0);
`ifdef UART_TXQ_LEVEL_EN
      check("rst_async_level", level, 0);
`endif
      n0 = rx_q.size();
      repeat (2) step();
      rst = 1'b1;
      repeat (60) step();
      check("rst_no_start_after", rx_q.size(), n0);
      push(8'h7A);
      wait_rx(n0 + 1, 200, "rst_new_push_timeout");
      if (rx_q.size() > n0) check("rst_new_push_data", rx_q[n0], 8'h7A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
